// File: rtl/alu_share_arb_if.sv
// One ALU client channel: valid/ready request carrying RV32I ALU controls plus a
// registered valid/ready result. The requester uses master and the arbiter uses slave.
interface alu_share_arb_if #(parameter int WIDTH = 32);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [2:0]       func3;
  logic             instr30;
  logic [1:0]       alu_op;
  logic             op2_sel;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, op1, op2, func3, instr30, alu_op, op2_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, op1, op2, func3, instr30, alu_op, op2_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_share_arb.sv
// Time-shares one RV32I ALU between the core execute port (C) and the WOS filter port (F).
// Build option ALU_ARB_RR_EN: round-robin on conflict; otherwise C-priority with F starvation guard.
module alu_share_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             gnt,
  input  logic             rsp_ready,
  input  logic [WIDTH-1:0] result,
  output logic             elig,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data
);
  // A full slot may still accept when it drains on the same edge.
  assign elig = req_valid && (!rsp_valid || rsp_ready) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (gnt) begin
      rsp_valid <= 1'b1;
      rsp_data  <= result;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

module alu_share_arb #(
  parameter int WIDTH      = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_share_arb_if.slave   c_port,
  alu_share_arb_if.slave   f_port,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [2:0]       alu_func3,
  output logic             alu_instr30,
  output logic [1:0]       alu_alu_op,
  output logic             alu_op2_sel,
  input  logic [WIDTH-1:0] alu_result
);
  localparam int NPORT = 2;  // index 0 = C, 1 = F

  typedef struct packed {
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [2:0]       func3;
    logic             instr30;
    logic [1:0]       alu_op;
    logic             op2_sel;
  } alu_req_t;

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("alu_share_arb: STARVE_MAX must be 1..15");
  end

  alu_req_t [NPORT-1:0]             req;
  alu_req_t                         alu_sel;
  logic [NPORT-1:0]                 req_valid, rsp_ready, rsp_valid, elig, gnt;
  logic [NPORT-1:0][WIDTH-1:0]      rsp_data;
  logic                             conflict, f_wins;

  assign req[0] = {c_port.op1, c_port.op2, c_port.func3, c_port.instr30,
                   c_port.alu_op, c_port.op2_sel};
  assign req[1] = {f_port.op1, f_port.op2, f_port.func3, f_port.instr30,
                   f_port.alu_op, f_port.op2_sel};
  assign req_valid = {f_port.req_valid, c_port.req_valid};
  assign rsp_ready = {f_port.rsp_ready, c_port.rsp_ready};

  for (genvar i = 0; i < NPORT; i++) begin : g_slot
    alu_share_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[i]),
      .gnt       (gnt[i]),
      .rsp_ready (rsp_ready[i]),
      .result    (alu_result),
      .elig      (elig[i]),
      .rsp_valid (rsp_valid[i]),
      .rsp_data  (rsp_data[i])
    );
  end

  assign conflict = &elig;

`ifdef ALU_ARB_RR_EN
  logic ptr;  // 0 prefers C, 1 prefers F

  assign f_wins = ptr;

  always_ff @(posedge clk) begin
    if (rst)       ptr <= 1'b0;
    else if (|gnt) ptr <= gnt[0];
  end
`else
  logic [3:0] starve;

  assign f_wins = (starve == 4'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (rst)           starve <= '0;
    else if (gnt[1])   starve <= '0;
    else if (conflict) starve <= starve + 4'd1;
  end
`endif

  always_comb begin
    gnt = elig;
    if (conflict) gnt = f_wins ? 2'b10 : 2'b01;
  end

  always_comb begin
    alu_sel = '0;
    if (gnt[0])      alu_sel = req[0];
    else if (gnt[1]) alu_sel = req[1];
  end

  assign alu_op1     = alu_sel.op1;
  assign alu_op2     = alu_sel.op2;
  assign alu_func3   = alu_sel.func3;
  assign alu_instr30 = alu_sel.instr30;
  assign alu_alu_op  = alu_sel.alu_op;
  assign alu_op2_sel = alu_sel.op2_sel;

  assign c_port.req_ready = gnt[0];
  assign f_port.req_ready = gnt[1];
  assign c_port.rsp_valid = rsp_valid[0];
  assign f_port.rsp_valid = rsp_valid[1];
  assign c_port.rsp_data  = rsp_data[0];
  assign f_port.rsp_data  = rsp_data[1];
endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: table of single ALU ops plus hand-built stall, conflict and
// reset sequences; results are matched through per-port expected-value queues.
module tb_alu_share_arb;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [2:0]  alu_func3;
  logic        alu_instr30, alu_op2_sel;
  logic [1:0]  alu_alu_op;

  alu_share_arb_if #(.WIDTH(32)) c_if ();
  alu_share_arb_if #(.WIDTH(32)) f_if ();

  alu_share_arb #(.WIDTH(32), .STARVE_MAX(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .c_port      (c_if),
    .f_port      (f_if),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_func3   (alu_func3),
    .alu_instr30 (alu_instr30),
    .alu_alu_op  (alu_alu_op),
    .alu_op2_sel (alu_op2_sel),
    .alu_result  (alu_result)
  );

  always #5 clk = ~clk;

  // Stand-in for the external combinational RV32I ALU.
  always_comb begin
    alu_result = 32'h0;
    case (alu_alu_op)
      2'b00: alu_result = alu_op1 + alu_op2;
      2'b01: case (alu_func3)
        3'b000: alu_result = (alu_instr30 && !alu_op2_sel) ? alu_op1 - alu_op2 : alu_op1 + alu_op2;
        3'b001: alu_result = alu_op1 << alu_op2[4:0];
        3'b010: alu_result = {31'b0, $signed(alu_op1) < $signed(alu_op2)};
        3'b011: alu_result = {31'b0, alu_op1 < alu_op2};
        3'b100: alu_result = alu_op1 ^ alu_op2;
        3'b101: alu_result = alu_instr30 ? 32'($signed(alu_op1) >>> alu_op2[4:0])
                                         : alu_op1 >> alu_op2[4:0];
        3'b110: alu_result = alu_op1 | alu_op2;
        default: alu_result = alu_op1 & alu_op2;
      endcase
      2'b10: alu_result = alu_op2;
      default: alu_result = 32'h0;
    endcase
  end

  typedef struct {
    bit          port;
    logic [31:0] op1, op2;
    logic [2:0]  f3;
    logic        i30;
    logic [1:0]  aop;
    logic        sel;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[12];
  logic [31:0] c_q[$], f_q[$];
  logic [31:0] c_exp, f_exp;
  logic [1:0]  gnt_log;
  logic [1:0]  gnt_exp;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    if (v.port == 1'b0) begin
      c_if.req_valid = 1'b1; c_if.op1 = v.op1; c_if.op2 = v.op2; c_if.func3 = v.f3;
      c_if.instr30 = v.i30; c_if.alu_op = v.aop; c_if.op2_sel = v.sel; c_exp = v.exp;
    end else begin
      f_if.req_valid = 1'b1; f_if.op1 = v.op1; f_if.op2 = v.op2; f_if.func3 = v.f3;
      f_if.instr30 = v.i30; f_if.alu_op = v.aop; f_if.op2_sel = v.sel; f_exp = v.exp;
    end
  endtask

  task automatic idle();
    c_if.req_valid = 1'b0; f_if.req_valid = 1'b0;
  endtask

  // One clock: sample handshakes mid-cycle, score results, push accepted requests.
  task automatic step();
    logic c_rq, f_rq, c_rs, f_rs;
    logic [31:0] cd, fd;
    @(negedge clk);
    c_rq = c_if.req_valid && c_if.req_ready;
    f_rq = f_if.req_valid && f_if.req_ready;
    c_rs = c_if.rsp_valid && c_if.rsp_ready;
    f_rs = f_if.rsp_valid && f_if.rsp_ready;
    cd = c_if.rsp_data; fd = f_if.rsp_data;
    if (c_rs) begin
      if (c_q.size() == 0) begin
        checks++; errors++; $display("FAIL c_rsp: unexpected result %0h, none required", cd);
      end else chk("c_rsp", cd, c_q.pop_front());
    end
    if (f_rs) begin
      if (f_q.size() == 0) begin
        checks++; errors++; $display("FAIL f_rsp: unexpected result %0h, none required", fd);
      end else chk("f_rsp", fd, f_q.pop_front());
    end
    if (c_rq) c_q.push_back(c_exp);
    if (f_rq) f_q.push_back(f_exp);
    gnt_log = {c_rq, f_rq};
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    c_q.delete(); f_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{0, 32'd5,        32'd3,        3'b000, 1, 2'b01, 0, 32'd2};
    vecs[1]  = '{1, 32'd5,        32'd3,        3'b000, 1, 2'b01, 1, 32'd8};
    vecs[2]  = '{0, 32'd7,        32'd9,        3'b000, 0, 2'b00, 0, 32'd16};
    vecs[3]  = '{1, 32'h1234,     32'hdead,     3'b000, 0, 2'b10, 1, 32'hdead};
    vecs[4]  = '{0, 32'd1,        32'd4,        3'b001, 0, 2'b01, 0, 32'd16};
    vecs[5]  = '{1, 32'hffffffff, 32'd1,        3'b010, 0, 2'b01, 0, 32'd1};
    vecs[6]  = '{0, 32'hffffffff, 32'd1,        3'b011, 0, 2'b01, 0, 32'd0};
    vecs[7]  = '{1, 32'hf0f0,     32'hff00,     3'b100, 0, 2'b01, 0, 32'h0ff0};
    vecs[8]  = '{0, 32'h80000000, 32'd4,        3'b101, 0, 2'b01, 0, 32'h08000000};
    vecs[9]  = '{1, 32'h80000000, 32'd4,        3'b101, 1, 2'b01, 0, 32'hf8000000};
    vecs[10] = '{0, 32'hf0f0,     32'h0f00,     3'b110, 0, 2'b01, 0, 32'hfff0};
    vecs[11] = '{1, 32'hf0f0,     32'hff00,     3'b111, 0, 2'b01, 0, 32'hf000};

    rst = 1'b1;
    c_if.req_valid = 0; c_if.op1 = 0; c_if.op2 = 0; c_if.func3 = 0; c_if.instr30 = 0;
    c_if.alu_op = 0; c_if.op2_sel = 0; c_if.rsp_ready = 1;
    f_if.req_valid = 0; f_if.op1 = 0; f_if.op2 = 0; f_if.func3 = 0; f_if.instr30 = 0;
    f_if.alu_op = 0; f_if.op2_sel = 0; f_if.rsp_ready = 1;
    c_exp = 0; f_exp = 0;
    step(); step();
    rst = 1'b0;

    chk("rst_c_rsp_valid", {31'b0, c_if.rsp_valid}, 0);
    chk("rst_c_rsp_data",  c_if.rsp_data, 0);
    chk("rst_f_rsp_valid", {31'b0, f_if.rsp_valid}, 0);
    chk("rst_f_rsp_data",  f_if.rsp_data, 0);

    // Idle: ALU inputs all zero, nothing granted.
    step();
    chk("idle_alu_op1", alu_op1, 0);
    chk("idle_alu_op2", alu_op2, 0);
    chk("idle_alu_ctl", {24'b0, alu_func3, alu_instr30, alu_alu_op, alu_op2_sel}, 0);
    chk("idle_ready",   {30'b0, c_if.req_ready, f_if.req_ready}, 0);

    // Table: single-port ops alternating C/F, back to back.
    for (int i = 0; i < 12; i++) begin
      idle();
      drive(vecs[i]);
      #1;
      chk("vec_ready", {30'b0, c_if.req_ready, f_if.req_ready},
          vecs[i].port ? 32'd1 : 32'd2);
      chk("vec_alu_op1", alu_op1, vecs[i].op1);
      chk("vec_alu_op2", alu_op2, vecs[i].op2);
      step();
      if (i == 0) begin
        chk("first_c_rsp_valid", {31'b0, c_if.rsp_valid}, 1);
        chk("first_c_rsp_data",  c_if.rsp_data, 2);
        chk("first_f_rsp_valid", {31'b0, f_if.rsp_valid}, 0);
      end
    end
    idle();
    step(); step();

    // Idle must not disturb a held result.
    c_if.rsp_ready = 0;
    drive(vecs[2]);
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_c_rsp_valid", {31'b0, c_if.rsp_valid}, 1);
      chk("hold_c_rsp_data",  c_if.rsp_data, 16);
    end
    c_if.rsp_ready = 1;
    step(); step();

    // F slot stalled: C granted every cycle, F held off until it drains.
    f_if.rsp_ready = 0;
    drive('{1, 32'h0, 32'habcd, 3'b000, 0, 2'b10, 1, 32'habcd});
    step();
    drive('{0, 32'd10, 32'd20, 3'b000, 0, 2'b00, 0, 32'd30});
    drive('{1, 32'h0, 32'h5555, 3'b000, 0, 2'b10, 1, 32'h5555});
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stall_ready", {30'b0, c_if.req_ready, f_if.req_ready}, 32'd2);
      chk("stall_f_data", f_if.rsp_data, 32'habcd);
      step();
    end
    f_if.rsp_ready = 1;
    c_if.req_valid = 0;
    #1;
    chk("drain_f_ready", {31'b0, f_if.req_ready}, 1);
    step();
    chk("overwrite_f_valid", {31'b0, f_if.rsp_valid}, 1);
    chk("overwrite_f_data",  f_if.rsp_data, 32'h5555);
    idle();
    step(); step();

    // Both ports continuously requesting from reset.
    do_reset();
    drive('{0, 32'd10, 32'd20, 3'b000, 0, 2'b00, 0, 32'd30});
    drive('{1, 32'h0, 32'habcd, 3'b000, 0, 2'b10, 1, 32'habcd});
    for (int k = 0; k < 10; k++) begin
      step();
`ifdef ALU_ARB_RR_EN
      gnt_exp = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
      gnt_exp = (k % 5 == 4) ? 2'b01 : 2'b10;
`endif
      chk("gnt_seq", {30'b0, gnt_log}, {30'b0, gnt_exp});
    end
    idle();
    step(); step();

    // Reset right after a C grant: result discarded, preference back to C.
    c_if.rsp_ready = 0;
    drive(vecs[0]);
    step();
    drive('{1, 32'h0, 32'h77, 3'b000, 0, 2'b10, 1, 32'h77});
    rst = 1'b1;
    #1;
    chk("rst_ready", {30'b0, c_if.req_ready, f_if.req_ready}, 0);
    chk("rst_alu_op2", alu_op2, 0);
    step();
    c_q.delete(); f_q.delete();
    chk("rst_mid_c_valid", {31'b0, c_if.rsp_valid}, 0);
    chk("rst_mid_c_data",  c_if.rsp_data, 0);
    rst = 1'b0;
    c_if.rsp_ready = 1;
    #1;
    chk("post_rst_ready", {30'b0, c_if.req_ready, f_if.req_ready}, 32'd2);
    step();
    idle();
    step(); step(); step();

    chk("c_q_empty", c_q.size(), 0);
    chk("f_q_empty", f_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port arbiter that time-shares the single RV32I ALU between the RISC-V core execute stage (port C) and the WOS filter engine (port F). Each port issues ALU operations over a valid/ready request channel and gets a registered result over a valid/ready response channel. The block drives the ALU's operand/control inputs combinationally from the granted request and captures the ALU result one cycle later.

## Interface
- WIDTH, 32, operand/result width
- STARVE_MAX, 4, consecutive lost conflicts after which F is force-granted (fixed-priority mode only); range 1–15

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- c_req_valid / f_req_valid  in  1  request present
- c_req_ready / f_req_ready  out  1  request accepted this cycle (equals grant)
- c_op1, c_op2 / f_op1, f_op2  in  WIDTH  operands
- c_func3 / f_func3  in  3  ALU func3
- c_instr30 / f_instr30  in  1  instruction bit 30
- c_alu_op / f_alu_op  in  2  ALU mode (00 add, 01 func3-decoded, 10 pass op2)
- c_op2_sel / f_op2_sel  in  1  0: register operand, 1: immediate
- c_rsp_valid / f_rsp_valid  out  1  result held
- c_rsp_ready / f_rsp_ready  in  1  result consumed
- c_rsp_data / f_rsp_data  out  WIDTH  result
- alu_op1, alu_op2  out  WIDTH  to ALU
- alu_func3  out  3; alu_instr30  out  1; alu_alu_op  out  2; alu_op2_sel  out  1  to ALU
- alu_result  in  WIDTH  from ALU (combinational)

## Operation
- Port X eligible when X_req_valid && (!X_rsp_valid || X_rsp_ready).
- At most one grant per cycle. Only one eligible → that port is granted.
- Both eligible (conflict): resolved per Configuration.
- Granted port's fields drive alu_* combinationally; no grant → all alu_* = 0 (alu_op 00).
- On grant: X_rsp_data <= alu_result, X_rsp_valid <= 1 same edge. Not granted and X_rsp_ready → X_rsp_valid <= 0; X_rsp_data holds its last value.
- Response slot full and not draining → port ineligible; X_req_ready stays 0 (request must be held stable by the requester).
- Simultaneous drain + new grant on same port: new result overwrites, rsp_valid stays 1 (back-to-back throughput 1/cycle per port).
- req_ready never depends on req_valid of the same port except through eligibility; no combinational path from rsp_ready to rsp_valid.

## Timing
- Request accepted at edge N → result visible on X_rsp_* after edge N (1-cycle latency).
- Aggregate throughput: 1 op/cycle. Single active port: 1 op/cycle when rsp_ready held high.
- Reset (any cycle, including mid-transfer): c/f_rsp_valid = 0, c/f_rsp_data = 0, round-robin pointer = C, starve counter = 0; pending held requests are re-arbitrated after reset deasserts, in-flight result discarded. req_ready = 0 while rst high.

## Configuration
- ALU_ARB_RR_EN defined: round-robin on conflict. 1-bit pointer names the preferred port; after any grant pointer moves to the other port. Starve counter absent.
- ALU_ARB_RR_EN undefined: fixed priority, C wins conflicts. 4-bit starve counter increments on each conflict lost by F, clears on any F grant; when counter == STARVE_MAX, F wins the next conflict. Pointer absent.

## Test plan
- Single C request op1=5, op2=3, alu_op=01, func3=000, instr30=1, op2_sel=0 → c_req_ready=1 same cycle, c_rsp_valid=1 next cycle, c_rsp_data=2; f_rsp_valid stays 0.
- Both ports valid continuously, rsp_ready=1 (RR build) → grants alternate C,F,C,F from reset; each port 1 result every 2 cycles.
- Both valid continuously, STARVE_MAX=4 (fixed build) → grant sequence C,C,C,C,F,C,C,C,C,F.
- F rsp_ready=0 with f_rsp_valid=1, both requesting → F ineligible, C granted every cycle; f_rsp_data unchanged until f_rsp_ready=1, then F re-eligible same cycle.
- No requests → all alu_* = 0, both req_ready = 0, rsp_valid unchanged by idle.
- Assert rst for one cycle right after a C grant → c_rsp_valid=0, c_rsp_data=0 after edge; RR pointer back to C.
